cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit, 4-register CPU. It owns the 4-bit program counter and the instruction register, and steps each instruction through fetch, decode, execute and writeback. It drives register-file read/write addresses, write enable and ALU opcode, and supports free-run, single-step and halt. It sits between the instruction ROM (combinational, addressed by `pc`) and the register-file/ALU datapath.

---
 rtl/cpu_sequencer.sv | 70 +++++++
 tb/tb_cpu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/wb control sequencer with PC, IR and zero flag
module cpu_sequencer #(
  parameter int PC_W = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      instr,
  input  logic            alu_zero,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      rf_raddr_a,
  output logic [1:0]      rf_raddr_b,
  output logic [1:0]      rf_waddr,
  output logic            rf_we,
  output logic [2:0]      alu_op,
  output logic            instr_done,
  output logic            halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
  state_t state;
  state_t nxt;
  logic [7:0] ir;
  logic [3:0] op;
  logic z_flag;
  logic is_alu;
  logic is_jmp;
  assign op = ir[7:4];
  assign is_alu = op >= 4'd1 && op <= 4'd7;
  assign is_jmp = op == 4'd8 || op == 4'd9;
  assign nxt = run ? FETCH : IDLE;
  assign rf_raddr_a = ir[3:2];
  assign rf_raddr_b = ir[1:0];
  assign rf_waddr = ir[3:2];
  assign alu_op = is_alu ? ir[6:4] : 3'd0;
  assign rf_we = state == WB;
  assign halted = state == HALT;
  // retiring cycle: NOP in DECODE, jump in EXEC, ALU op in WB
  assign instr_done = (state == DECODE && !is_alu && !is_jmp && op != 4'hf) ||
                      (state == EXEC && is_jmp) || state == WB;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      z_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= (run || step) ? FETCH : IDLE;
        FETCH: begin
          ir <= instr;
          pc <= pc + PC_W'(1);
          state <= DECODE;
        end
        DECODE: state <= op == 4'hf ? HALT : (is_alu || is_jmp) ? EXEC : nxt;
        EXEC: begin
          state <= is_alu ? WB : nxt;
          if (op == 4'd8 || (op == 4'd9 && z_flag)) pc <= PC_W'(ir[3:0]);
        end
        WB: begin
          z_flag <= alu_zero;
          state <= nxt;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven, directed and randomized checks of cpu_sequencer against an instruction-level model
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic reset, run, step, alu_zero;
  logic [7:0] instr;
  logic [3:0] pc;
  logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic rf_we, instr_done, halted;
  logic [2:0] alu_op;
  logic [7:0] rom [16];
  int n_chk = 0;
  int n_fail = 0;

  assign instr = rom[pc];
  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(4), .RESET_PC(4'd0)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .run(run), .step(step),
    .pc(pc), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .alu_op(alu_op), .instr_done(instr_done), .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // instruction-level model: cycle index within the current instruction and its latency
  logic m_busy, m_halt, m_z;
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  int m_k, m_lat;

  task automatic model_edge();
    logic [3:0] o;
    if (!reset) begin
      m_busy = 0; m_halt = 0; m_k = 0; m_lat = 0; m_pc = 0; m_ir = 0; m_z = 0;
    end else if (m_halt) begin
    end else if (!m_busy) begin
      if (run || step) begin m_busy = 1; m_k = 1; end
    end else if (m_k == 1) begin
      m_ir = rom[m_pc];
      m_pc = m_pc + 4'd1;
      o = m_ir[7:4];
      m_lat = (o >= 1 && o <= 7) ? 4 : (o == 8 || o == 9) ? 3 : 2;
      m_k = 2;
    end else if (m_k == m_lat) begin
      o = m_ir[7:4];
      if (o == 4'hf) begin
        m_halt = 1; m_busy = 0;
      end else begin
        if (o == 8 || (o == 9 && m_z)) m_pc = m_ir[3:0];
        if (m_lat == 4) m_z = alu_zero;
        m_busy = run; m_k = 1;
      end
    end else m_k++;
  endtask

  function automatic logic [15:0] model_out();
    logic [3:0] o;
    logic we, done;
    logic [2:0] aop;
    o = m_ir[7:4];
    we = m_busy && m_k == 4 && m_lat == 4;
    done = m_busy && m_k > 1 && m_k == m_lat && o != 4'hf;
    aop = (o >= 1 && o <= 7) ? o[2:0] : 3'd0;
    return {m_pc, m_ir[3:2], m_ir[1:0], m_ir[3:2], we, aop, done, m_halt};
  endfunction

  typedef struct {
    logic [7:0] instr;
    int         lat;
    logic       we;
    logic [2:0] op;
    logic [3:0] pc_after;
    logic       halt;
  } vec_t;

  vec_t tbl [8];
  logic [3:0] pcs [16];
  logic dn [16];
  logic we_seen, stable;
  int got, dcount;

  initial begin
    tbl[0] = '{8'h00, 2, 1'b0, 3'd0, 4'd1, 1'b0};
    tbl[1] = '{8'h16, 4, 1'b1, 3'd1, 4'd1, 1'b0};
    tbl[2] = '{8'h2B, 4, 1'b1, 3'd2, 4'd1, 1'b0};
    tbl[3] = '{8'h7E, 4, 1'b1, 3'd7, 4'd1, 1'b0};
    tbl[4] = '{8'h85, 3, 1'b0, 3'd0, 4'd5, 1'b0};
    tbl[5] = '{8'h9A, 3, 1'b0, 3'd0, 4'd1, 1'b0};
    tbl[6] = '{8'hC3, 2, 1'b0, 3'd0, 4'd1, 1'b0};
    tbl[7] = '{8'hF0, 3, 1'b0, 3'd0, 4'd1, 1'b1};
    alu_zero = 1'b0;
    clear_rom();

    // reset and idle
    do_reset();
    tick();
    check("reset_pc", pc, 0);
    check("reset_halted", halted, 0);
    check("reset_done", instr_done, 0);
    check("reset_aluop", alu_op, 0);
    check("reset_addr", {rf_raddr_a, rf_raddr_b, rf_waddr}, 0);
    we_seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); we_seen |= rf_we; end
    check("idle_no_we", we_seen, 0);

    // single-instruction table via step
    for (int t = 0; t < 8; t++) begin
      clear_rom();
      rom[0] = tbl[t].instr;
      do_reset();
      step = 1'b1;
      tick();
      step = 1'b0;
      we_seen = rf_we;
      got = 0;
      for (int c = 2; c <= 10; c++) begin
        tick();
        we_seen |= rf_we;
        if (instr_done || halted) begin got = c; break; end
      end
      tick();
      check($sformatf("tbl%0d_lat", t), got, tbl[t].lat);
      check($sformatf("tbl%0d_we", t), we_seen, tbl[t].we);
      check($sformatf("tbl%0d_aluop", t), alu_op, tbl[t].op);
      check($sformatf("tbl%0d_pc", t), pc, tbl[t].pc_after);
      check($sformatf("tbl%0d_halt", t), halted, tbl[t].halt);
    end

    // free-run ALU sequence
    clear_rom();
    rom[0] = 8'h61; rom[1] = 8'h14;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("seq_we_c%0d", c), rf_we, c == 4 || c == 8);
      check($sformatf("seq_done_c%0d", c), instr_done, c == 4 || c == 8);
      if (c == 4) check("seq_waddr_c4", rf_waddr, 0);
      if (c == 8) begin check("seq_waddr_c8", rf_waddr, 1); check("seq_pc_c8", pc, 2); end
    end
    run = 1'b0;

    // JZ taken / not taken after ADD
    for (int z = 1; z >= 0; z--) begin
      clear_rom();
      rom[0] = 8'h14; rom[1] = 8'h9A;
      do_reset();
      alu_zero = z[0];
      run = 1'b1;
      for (int c = 1; c <= 8; c++) tick();
      check($sformatf("jz_z%0d_pc", z), pc, z ? 10 : 2);
      run = 1'b0;
    end
    alu_zero = 1'b0;

    // JMP to 15 then PC wrap
    clear_rom();
    rom[0] = 8'h8F;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 9; c++) begin tick(); pcs[c] = pc; dn[c] = instr_done; end
    run = 1'b0;
    check("wrap_pc_c4", pcs[4], 15);
    check("wrap_pc_c5", pcs[5], 0);
    check("wrap_done_c5", dn[5], 1);
    check("wrap_pc_c7", pcs[7], 1);
    check("wrap_pc_c9", pcs[9], 15);

    // single step with a second pulse mid-instruction
    clear_rom();
    rom[0] = 8'h14;
    do_reset();
    step = 1'b1; tick(); step = 1'b0;
    dcount = 0;
    for (int c = 2; c <= 12; c++) begin
      step = (c == 2);
      tick();
      if (instr_done) dcount++;
    end
    step = 1'b0;
    check("step_done_count", dcount, 1);
    check("step_pc", pc, 1);

    // halt, stable despite run/step, then reset during a WB
    clear_rom();
    rom[3] = 8'hF0;
    do_reset();
    run = 1'b1;
    got = 0;
    for (int c = 1; c <= 30; c++) begin tick(); if (halted) begin got = 1; break; end end
    check("halt_reached", got, 1);
    check("halt_pc", pc, 4);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      tick();
      stable &= halted && pc == 4'd4 && !instr_done && !rf_we;
    end
    check("halt_stable", stable, 1);
    rom[0] = 8'h14;
    do_reset();
    run = 1'b1; step = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    check("wb_we", rf_we, 1);
    reset = 1'b0;
    tick();
    check("wbrst_pc", pc, 0);
    check("wbrst_halted", halted, 0);
    check("wbrst_we", rf_we, 0);
    reset = 1'b1; run = 1'b0;

    // randomized run against the instruction-level model
    reset = 1'b0;
    model_edge();
    tick();
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 150) != 0;
      if (!reset) for (int j = 0; j < 16; j++) rom[j] = 8'($urandom);
      if ($urandom_range(0, 20) == 0) run = ~run;
      step = $urandom_range(0, 5) == 0;
      alu_zero = 1'($urandom_range(0, 1));
      model_edge();
      tick();
      check($sformatf("rand_%0d", i),
            {pc, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, alu_op, instr_done, halted}, model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
